// File: rtl/ram_copy_dma.sv
// Word-by-word memory-to-memory copy engine: read one word, write it, repeat.
// Single-port memory with a one-cycle response strobe for every request.
module ram_copy_dma #(
  parameter int unsigned LenW          = 16,
  parameter int unsigned TimeoutCycles = 15
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [LenW-1:0] words_done_o,
  output logic            req_o,
  output logic            we_o,
  output logic [3:0]      be_o,
  output logic [31:0]     addr_o,
  output logic [31:0]     wdata_o,
  input  logic [31:0]     rdata_i,
  input  logic            rvalid_i
);

  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, WR, FIN
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [31:0]     data_q, data_d;
  logic [LenW-1:0] rem_q, rem_d;
  logic [LenW-1:0] wd_q, wd_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;

  logic misaligned;
  assign misaligned = (src_addr_i[1:0] != 2'b00) ||
                      (dst_addr_i[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else if (len_i == '0) begin
            wd_d    = '0;
            state_d = FIN;
          end else begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            rem_d   = len_i;
            wd_d    = '0;
            state_d = RD;
          end
        end
      end
      RD: begin
        tmo_d   = '0;
        state_d = abort_i ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (rvalid_i) begin
          data_d  = rdata_i;
          state_d = WR;
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WR: begin
        // The write issued this cycle always lands, even on abort.
        wd_d  = wd_q + 1'b1;
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        rem_d = rem_q - 1'b1;
        if (abort_i) begin
          state_d = IDLE;
        end else if (rem_q == LenW'(1)) begin
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  logic in_rd, in_wr;
  assign in_rd = (state_q == RD);
  assign in_wr = (state_q == WR);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FIN);
  assign err_o        = err_q;
  assign words_done_o = wd_q;
  assign req_o        = in_rd | in_wr;
  assign we_o         = in_wr;
  assign be_o         = in_wr ? 4'hF : 4'h0;
  assign addr_o       = in_rd ? src_q : (in_wr ? dst_q : 32'h0);
  assign wdata_o      = in_wr ? data_q : 32'h0;

endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma with a 1-cycle-latency memory model.
// Vector table for whole transfers, hand sequences for timeout/abort/reset.
module tb_ram_copy_dma;

  localparam int LenW = 16;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [31:0]     src_addr_i = '0;
  logic [31:0]     dst_addr_i = '0;
  logic [LenW-1:0] len_i = '0;
  logic            busy_o, done_o, err_o;
  logic [LenW-1:0] words_done_o;
  logic            req_o, we_o;
  logic [3:0]      be_o;
  logic [31:0]     addr_o, wdata_o;
  logic [31:0]     rdata_i = '0;
  logic            rvalid_i = 1'b0;

  ram_copy_dma #(.LenW(LenW), .TimeoutCycles(15)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .words_done_o(words_done_o), .req_o(req_o), .we_o(we_o),
    .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] src_word(input logic [7:0] i);
    if (i < 8'd4) return 32'h11111111 * {24'h0, i + 8'd1};
    return {16'hA5A5, 8'h00, i};
  endfunction

  // Memory: source words come from src_word(), writes go to wmem.
  logic        resp_en = 1'b1;
  logic [31:0] wmem [256];
  always @(posedge clk) begin
    rvalid_i <= req_o & resp_en;
    rdata_i  <= src_word(addr_o[9:2]);
    if (req_o && we_o) wmem[addr_o[9:2]] <= wdata_o;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_req = 0, n_done = 0, n_err = 0, n_busy = 0, n_rd = 0;
  int done_cyc = 0, err_cyc = 0;
  logic [31:0] rd_log [128];
  always @(negedge clk) begin
    if (req_o) begin
      n_req++;
      if (!we_o && n_rd < 128) begin
        rd_log[n_rd] = addr_o;
        n_rd++;
      end
    end
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (err_o) begin n_err++; err_cyc = cyc; end
    if (busy_o) n_busy++;
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int t0, b_req, b_done, b_err, b_busy, b_rd;

  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input int l, input logic ab);
    @(negedge clk);
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = LenW'(l);
    start_i    = 1'b1;
    abort_i    = ab;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    t0 = cyc;
    b_req = n_req; b_done = n_done; b_err = n_err;
    b_busy = n_busy; b_rd = n_rd;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    chk("idle_reached", 64'(ok), 64'd1);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cyc == target) break;
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int len, reqs, dones, errs, words;
  } vec_t;

  vec_t v [6];

  initial begin
    v[0] = '{32'h000,      32'h100, 4, 8, 1, 0, 4};
    v[1] = '{32'h002,      32'h100, 4, 0, 0, 1, 4};
    v[2] = '{32'h000,      32'h100, 0, 0, 1, 0, 0};
    v[3] = '{32'h000,      32'h101, 2, 0, 0, 1, 0};
    v[4] = '{32'h040,      32'h200, 3, 6, 1, 0, 3};
    v[5] = '{32'hFFFFFFFC, 32'h300, 2, 4, 1, 0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(|{req_o, we_o, busy_o, done_o, err_o, be_o,
        addr_o, wdata_o, words_done_o}), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      launch(v[i].src, v[i].dst, v[i].len, 1'b0);
      wait_idle();
      chk($sformatf("v%0d_reqs", i), 64'(n_req - b_req), 64'(v[i].reqs));
      chk($sformatf("v%0d_done", i), 64'(n_done - b_done), 64'(v[i].dones));
      chk($sformatf("v%0d_err", i), 64'(n_err - b_err), 64'(v[i].errs));
      chk($sformatf("v%0d_words", i), 64'(words_done_o), 64'(v[i].words));
      if (v[i].dones != 0) begin
        chk($sformatf("v%0d_latency", i), 64'(done_cyc - t0),
            64'(3 * v[i].len));
        chk($sformatf("v%0d_busy", i), 64'(n_busy - b_busy),
            64'(3 * v[i].len + 1));
        for (int w = 0; w < v[i].len; w++) begin
          logic [31:0] sa, da;
          sa = v[i].src + 32'(4 * w);
          da = v[i].dst + 32'(4 * w);
          chk($sformatf("v%0d_rdaddr%0d", i, w), 64'(rd_log[b_rd + w]),
              64'(sa));
          chk($sformatf("v%0d_data%0d", i, w), 64'(wmem[da[9:2]]),
              64'(src_word(sa[9:2])));
        end
      end else begin
        chk($sformatf("v%0d_busy", i), 64'(n_busy - b_busy), 64'd0);
      end
    end

    // Read response never arrives.
    resp_en = 1'b0;
    launch(32'h000, 32'h100, 2, 1'b0);
    wait_idle();
    resp_en = 1'b1;
    chk("tmo_reqs", 64'(n_req - b_req), 64'd1);
    chk("tmo_err", 64'(n_err - b_err), 64'd1);
    chk("tmo_done", 64'(n_done - b_done), 64'd0);
    chk("tmo_cycle", 64'(err_cyc - t0), 64'd16);
    chk("tmo_busy", 64'(n_busy - b_busy), 64'd16);
    chk("tmo_words", 64'(words_done_o), 64'd0);

    // Abort during the second write.
    launch(32'h000, 32'h140, 8, 1'b0);
    wait_cyc(t0 + 5);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_reqs", 64'(n_req - b_req), 64'd4);
    chk("abort_words", 64'(words_done_o), 64'd2);
    chk("abort_done", 64'(n_done - b_done), 64'd0);
    chk("abort_err", 64'(n_err - b_err), 64'd0);
    chk("abort_data1", 64'(wmem[8'h51]), 64'(src_word(8'd1)));

    // Start and abort together in IDLE: start wins.
    launch(32'h010, 32'h380, 1, 1'b1);
    wait_idle();
    chk("stab_done", 64'(n_done - b_done), 64'd1);
    chk("stab_words", 64'(words_done_o), 64'd1);

    // A second start while busy is ignored.
    launch(32'h020, 32'h3C0, 2, 1'b0);
    wait_cyc(t0 + 1);
    start_i    = 1'b1;
    src_addr_i = 32'h2;
    len_i      = LenW'(7);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_idle();
    chk("busy_start_reqs", 64'(n_req - b_req), 64'd4);
    chk("busy_start_words", 64'(words_done_o), 64'd2);
    chk("busy_start_err", 64'(n_err - b_err), 64'd0);
    chk("busy_start_done", 64'(n_done - b_done), 64'd1);

    // Reset while waiting on the second read.
    launch(32'h000, 32'h100, 4, 1'b0);
    wait_cyc(t0 + 4);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_outputs", 64'(|{req_o, we_o, busy_o, done_o, err_o, be_o,
        addr_o, wdata_o, words_done_o}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_reqs", 64'(n_req - b_req), 64'd3);
    chk("rst_mid_done", 64'(n_done - b_done), 64'd0);
    chk("rst_mid_err", 64'(n_err - b_err), 64'd0);
    rst_ni = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ram_copy_dma.md
RAM_COPY_DMA -- requirements
Module: ram_copy_dma

Interface
REQ-001 Parameter LenW, default 16, width of length and progress counters.
REQ-002 Parameter TimeoutCycles, default 15, maximum WAIT cycles without rvalid_i before error.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 start_i  input  1  start request, sampled in IDLE only.
REQ-006 abort_i  input  1  abort running transfer.
REQ-007 src_addr_i  input  32  source byte address, sampled on accepted start.
REQ-008 dst_addr_i  input  32  destination byte address, sampled on accepted start.
REQ-009 len_i  input  LenW  word count, sampled on accepted start.
REQ-010 busy_o  output  1  high while state is not IDLE.
REQ-011 done_o  output  1  one-cycle pulse on normal completion.
REQ-012 err_o  output  1  one-cycle pulse on misalignment or timeout.
REQ-013 words_done_o  output  LenW  count of words written in current/last transfer.
REQ-014 req_o  output  1  memory request.
REQ-015 we_o  output  1  1 = write, 0 = read; valid with req_o.
REQ-016 be_o  output  4  byte enables; 4'hF when we_o=1, 4'h0 otherwise.
REQ-017 addr_o  output  32  memory byte address.
REQ-018 wdata_o  output  32  write data.
REQ-019 rdata_i  input  32  read data, valid with rvalid_i.
REQ-020 rvalid_i  input  1  response strobe, one cycle after each accepted req_o (reads and writes).

Function
REQ-021 States: IDLE, RD, WAIT, WR, FIN; req_o/we_o/addr_o/wdata_o decoded from registered state and address/data registers only.
REQ-022 IDLE + start_i=1: src or dst bits[1:0]!=0 -> err_o pulse next cycle, stay IDLE, no req_o; len_i=0 -> FIN, no req_o; else latch src/dst/len, clear words_done_o, -> RD.
REQ-023 RD: req_o=1, we_o=0, addr_o=src pointer; -> WAIT next cycle unconditionally; memory accepts every request (no grant).
REQ-024 WAIT: req_o=0; rvalid_i=1 -> capture rdata_i into data register, -> WR; rvalid_i=0 -> increment timeout counter, stay.
REQ-025 WAIT timeout: counter reaching TimeoutCycles with no rvalid_i -> err_o pulse, -> IDLE; counter cleared on every entry to WAIT.
REQ-026 WR: req_o=1, we_o=1, be_o=4'hF, addr_o=dst pointer, wdata_o=captured data; at edge: words_done_o+1, src+4, dst+4, remaining-1; remaining reaching 0 -> FIN, else -> RD.
REQ-027 rvalid_i outside WAIT (e.g. write response arriving in RD or FIN) SHALL be ignored.
REQ-028 FIN: done_o=1 for exactly one cycle, -> IDLE; busy_o high in FIN.
REQ-029 Throughput: exactly 3 cycles per word with 1-cycle-latency memory; transfer of N words, start accepted at edge T, done_o high in cycle T+3N.
REQ-030 Address pointers wrap modulo 2^32 without error.
REQ-031 start_i while busy_o=1 ignored; inputs not re-sampled.
REQ-032 abort_i=1 in RD/WAIT/WR: request already driven that cycle completes; next state IDLE; no done_o, no err_o; words_done_o holds count of completed writes (including a WR in the abort cycle).
REQ-033 abort_i in IDLE or FIN has no effect; abort and start same cycle in IDLE: start wins.
REQ-034 words_done_o holds its value in IDLE until next accepted start.

Reset
REQ-035 rst_ni=0 at rising edge: state IDLE; req_o, we_o, busy_o, done_o, err_o = 0; be_o=4'h0; addr_o, wdata_o, words_done_o, pointers, timeout counter = 0.
REQ-036 Reset mid-transfer takes effect at the next edge; no further req_o issued, no done_o/err_o pulse.

Verification
REQ-037 Copy src=0x000, dst=0x100, len=4 with words 0x11111111..0x44444444 -> 4 reads then writes, dst holds data, done_o at T+12, words_done_o=4.
REQ-038 len=0 -> no req_o, done_o one cycle after start, words_done_o=0.
REQ-039 src=0x002 -> err_o pulse, no req_o, busy_o stays 0.
REQ-040 rvalid_i held low after read -> err_o after 15 WAIT cycles, IDLE, words_done_o=0.
REQ-041 len=8, abort_i at second WR -> no further req_o, words_done_o=2, no done_o.
REQ-042 src=0xFFFFFFFC, len=2 -> second read addr_o=0x00000000; rst_ni low during WAIT -> all outputs 0 next cycle.
